// File: rtl/ssq_pkg.sv
// Shared types and default delimiter tokens for the stream stack/queue buffer.
package ssq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        POP_LIFO   = 2'd2,
        DRAIN_FIFO = 2'd3
    } state_t;

    localparam int SSQ_SEP_TOK  = 59;  // ';'
    localparam int SSQ_END_TOK  = 36;  // '$'
    localparam int SSQ_ZERO_TOK = 48;  // '0'

endpackage

// File: rtl/ssq_stack_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module ssq_stack_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_stack_queue.sv
// Stack/queue buffer: data items are stacked, SEP pops a LIFO group, END drains the rest FIFO.
// Handshake: a beat transfers on a rising edge where valid and ready are both high; data is held while valid & ~ready.
module stream_stack_queue
    import ssq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 4,
    parameter int SEP_TOK  = SSQ_SEP_TOK,
    parameter int END_TOK  = SSQ_END_TOK,
    parameter int ZERO_TOK = SSQ_ZERO_TOK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  pop_num,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_fifo,
    output logic              done_fifo,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output state_t            state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = (CNT_W > CW) ? CNT_W : CW;

    state_t            state;
    logic [CW-1:0]     count;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     grp;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     raddr;
    logic [DATA_W-1:0] rdata;
    logic [MW-1:0]     pop_ext;
    logic [MW-1:0]     cnt_ext;
    logic [CW-1:0]     grp_next;
    logic              is_sep;
    logic              is_end;
    logic              push_we;

    assign is_sep   = (in_data == DATA_W'(SEP_TOK));
    assign is_end   = (in_data == DATA_W'(END_TOK));
    assign in_ready = (state == IDLE) || (state == WRITE);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_we  = in_valid && in_ready && !is_sep && !is_end && !full;

    // min(pop_num, count); a zero pop_num naturally yields an empty group.
    assign pop_ext  = MW'(pop_num);
    assign cnt_ext  = MW'(count);
    assign grp_next = (pop_ext < cnt_ext) ? CW'(pop_ext) : count;

    assign top_idx  = AW'(count - CW'(1));
    assign raddr    = (state == POP_LIFO) ? top_idx : rd_ptr;

    ssq_stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push_we),
        .waddr (count[AW-1:0]),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_fifo  = 1'b0;
        out_data  = rdata;
        case (state)
            POP_LIFO: begin
                out_valid = 1'b1;
                out_last  = (grp <= CW'(1));
                if (grp == '0) out_data = DATA_W'(ZERO_TOK);
            end
            DRAIN_FIFO: begin
                out_valid = 1'b1;
                out_fifo  = 1'b1;
                out_last  = (rd_ptr == top_idx);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            grp       <= '0;
            overflow  <= 1'b0;
            done_fifo <= 1'b0;
        end else begin
            done_fifo <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    if (in_valid) begin
                        state <= WRITE;
                        if (is_sep) begin
                            grp   <= grp_next;
                            state <= POP_LIFO;
                        end else if (is_end) begin
                            rd_ptr <= '0;
                            if (count == '0) begin
                                state     <= IDLE;
                                done_fifo <= 1'b1;
                            end else begin
                                state <= DRAIN_FIFO;
                            end
                        end else if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                POP_LIFO: begin
                    if (out_ready) begin
                        if (grp == '0) begin
                            state <= WRITE;
                        end else begin
                            count <= count - CW'(1);
                            grp   <= grp - CW'(1);
                            if (grp == CW'(1)) state <= WRITE;
                        end
                    end
                end
                DRAIN_FIFO: begin
                    if (out_ready) begin
                        if (rd_ptr == top_idx) begin
                            count     <= '0;
                            rd_ptr    <= '0;
                            state     <= IDLE;
                            done_fifo <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_stream_stack_queue.sv
// Directed bench for stream_stack_queue: LIFO groups, FIFO drains, overflow, stalls, reset.
module tb_stream_stack_queue;
    import ssq_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]  pop_num;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_fifo;
    logic              done_fifo;
    logic              full;
    logic              empty;
    logic              overflow;
    state_t            state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_stack_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pop_num   (pop_num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_fifo  (out_fifo),
        .done_fifo (done_fifo),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One input beat; waits (bounded) for in_ready at the falling edge.
    task automatic send(input logic [7:0] d, input logic [3:0] pn);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        pop_num  = pn;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // One output beat: check fields at the falling edge, then handshake.
    task automatic recv(input string tag, input logic [7:0] d, input logic last, input logic fifo);
        int waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk({tag, "_fifo"},  32'(out_fifo),  32'(fifo));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic chk_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done_fifo), 32'd1);
        chk({tag, "_state_idle"}, 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        chk({tag, "_done_clear"}, 32'(done_fifo), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; pop_num = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_empty",    32'(empty),     32'd1);
        chk("rst_full",     32'(full),      32'd0);
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_done",     32'(done_fifo), 32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd1);
        chk("rst_state",    32'(state_dbg), 32'(IDLE));

        // "abc" ; pop 2 -> c, b ; END -> a
        send("a", 0); send("b", 0); send("c", 0);
        send(8'd59, 4'd2);
        recv("t1_c", "c", 1'b0, 1'b0);
        recv("t1_b", "b", 1'b1, 1'b0);
        send(8'd36, 0);
        recv("t1_a", "a", 1'b1, 1'b1);
        chk_done("t1");
        chk("t1_empty", 32'(empty), 32'd1);

        // "xy" ; pop 0 -> single '0', stack untouched
        send("x", 0); send("y", 0);
        send(8'd59, 4'd0);
        recv("t2_zero", "0", 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_not_empty", 32'(empty), 32'd0);
        send(8'd36, 0);
        recv("t2_x", "x", 1'b0, 1'b1);
        recv("t2_y", "y", 1'b1, 1'b1);
        chk_done("t2");

        // "q" ; pop 5 clamps to 1 ; pop 3 on empty -> '0'
        send("q", 0);
        send(8'd59, 4'd5);
        recv("t3_q", "q", 1'b1, 1'b0);
        send(8'd59, 4'd3);
        recv("t3_zero", "0", 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_empty", 32'(empty), 32'd1);

        // 17 pushes into 16 entries: last one dropped
        for (int i = 1; i <= 17; i++) send(8'(i), 0);
        @(negedge clk);
        chk("t4_full",     32'(full),     32'd1);
        chk("t4_overflow", 32'(overflow), 32'd1);
        send(8'd36, 0);
        for (int i = 1; i <= 16; i++) recv("t4_drain", 8'(i), (i == 16), 1'b1);
        chk_done("t4");
        chk("t4_empty_after", 32'(empty),    32'd1);
        chk("t4_ovf_sticky",  32'(overflow), 32'd1);

        // stall mid-group for 3 cycles
        send("m", 0); send("n", 0); send("o", 0); send("p", 0);
        send(8'd59, 4'd4);
        recv("t5_p", "p", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_data",  32'(out_data),  32'("o"));
        end
        recv("t5_o", "o", 1'b0, 1'b0);
        recv("t5_n", "n", 1'b0, 1'b0);
        recv("t5_m", "m", 1'b1, 1'b0);

        // reset in the middle of a drain
        send("r", 0); send("s", 0); send("t", 0);
        send(8'd36, 0);
        recv("t6_r", "r", 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_valid",    32'(out_valid), 32'd0);
        chk("t6_empty",    32'(empty),     32'd1);
        chk("t6_state",    32'(state_dbg), 32'(IDLE));
        chk("t6_overflow", 32'(overflow),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
